// File: rtl/veri_commit_pkg.sv
// Shared sizes and commit-record layout for the OOO commit port.
// The record layout {pc, wen, rd, data} is the contract between the ROB
// and veri_commit_port; both sides size their storage with CM_REC_W.
package veri_commit_pkg;

    localparam int RF_SIZE  = 4;
    localparam int RF_IDX_W = 2;
    localparam int DATA_W   = 8;
    localparam int PC_W     = 4;
    localparam int Q_DEPTH  = 4;
    localparam int WDOG_MAX = 10;
    localparam int CNT_W    = 16;

    // Idle counter saturates at WDOG_MAX, so it needs to hold that value.
    localparam int IDLE_W   = $clog2(WDOG_MAX + 1);

    localparam int CM_REC_W = PC_W + 1 + RF_IDX_W + DATA_W;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic                wen;
        logic [RF_IDX_W-1:0] rd;
        logic [DATA_W-1:0]   data;
    } cm_rec_t;

endpackage

// File: rtl/veri_commit_port_commit_fifo.sv
// commit_fifo: small synchronous FIFO holding retired-instruction records
// between the ROB handshake and the shadow-RF update.
// Ports:
//   clk, rst   clock and synchronous active-high reset (empties the queue)
//   push       write push_data this edge (ignored when full)
//   push_data  record to enqueue
//   pop        drop the head entry this edge (ignored when empty)
//   full       occupancy == DEPTH
//   empty      occupancy == 0
//   head       oldest entry, valid whenever !empty
// The head is read combinationally so a record can be applied on the same
// edge it is popped; the storage is a handful of entries, so it maps to
// registers rather than block RAM.
module commit_fifo
    import veri_commit_pkg::*;
#(
    parameter int WIDTH = CM_REC_W,
    parameter int DEPTH = Q_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    // One extra bit so that full and empty are distinguishable.
    logic [PTR_W:0]   count_reg;

    logic push_ok;
    logic pop_ok;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/veri_commit_port.sv
// veri_commit_port: producer side of the OOO-vs-ISA lockstep check.
// Buffers retired-instruction records from the ROB head and applies exactly
// one per cycle to a shadow architectural register file.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   init_rf_flat     RF contents loaded on every rst cycle (entry p at [p*DATA_W +: DATA_W])
//   cm_valid/ready   record handshake from the ROB
//   cm_pc/wen/rd/data retired record fields
//   veri_commit      one-cycle pulse per applied record
//   veri_pc_last     pc of the most recently applied record
//   veri_rf_flat     shadow RF, same packing as init_rf_flat
//   veri_commit_cnt  records applied since reset (wraps)
//   veri_live        low once WDOG_MAX consecutive cycles pass with no commit
module veri_commit_port
    import veri_commit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RF_SIZE*DATA_W-1:0] init_rf_flat,
    input  logic                      cm_valid,
    output logic                      cm_ready,
    input  logic [PC_W-1:0]           cm_pc,
    input  logic                      cm_wen,
    input  logic [RF_IDX_W-1:0]       cm_rd,
    input  logic [DATA_W-1:0]         cm_data,
    output logic                      veri_commit,
    output logic [PC_W-1:0]           veri_pc_last,
    output logic [RF_SIZE*DATA_W-1:0] veri_rf_flat,
    output logic [CNT_W-1:0]          veri_commit_cnt,
    output logic                      veri_live
);

    logic    fifo_full;
    logic    fifo_empty;
    logic    push;
    logic    apply;
    cm_rec_t in_rec;
    cm_rec_t head_rec;

    logic              commit_reg;
    logic [PC_W-1:0]   pc_last_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [IDLE_W-1:0] idle_reg;

    // Ready depends only on queue state and rst, never on cm_valid.
    assign cm_ready = !fifo_full && !rst;
    assign push     = cm_valid && cm_ready;
    // Emptiness is sampled before this edge's enqueue, so there is no bypass:
    // a record always spends at least one cycle in the queue.
    assign apply    = !fifo_empty;

    assign in_rec = '{pc: cm_pc, wen: cm_wen, rd: cm_rd, data: cm_data};

    commit_fifo #(
        .WIDTH(CM_REC_W),
        .DEPTH(Q_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_rec),
        .pop       (apply),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_rec)
    );

    // Shadow RF: one register per architectural entry. r0 is an ordinary
    // writable register, matching the ISA model.
    generate
        for (genvar gi = 0; gi < RF_SIZE; gi++) begin : g_rf
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= init_rf_flat[gi*DATA_W +: DATA_W];
                end else if (apply && head_rec.wen && (head_rec.rd == RF_IDX_W'(gi))) begin
                    entry_reg <= head_rec.data;
                end
            end

            assign veri_rf_flat[gi*DATA_W +: DATA_W] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_reg  <= 1'b0;
            pc_last_reg <= '0;
            cnt_reg     <= '0;
            idle_reg    <= '0;
        end else if (apply) begin
            commit_reg  <= 1'b1;
            pc_last_reg <= head_rec.pc;
            cnt_reg     <= cnt_reg + CNT_W'(1);
            idle_reg    <= '0;
        end else begin
            commit_reg  <= 1'b0;
            // Saturate so the counter never wraps back into the "live" range.
            if (idle_reg < IDLE_W'(WDOG_MAX)) begin
                idle_reg <= idle_reg + IDLE_W'(1);
            end
        end
    end

    assign veri_commit     = commit_reg;
    assign veri_pc_last    = pc_last_reg;
    assign veri_commit_cnt = cnt_reg;
    assign veri_live       = (idle_reg < IDLE_W'(WDOG_MAX));

endmodule

// File: tb/tb_veri_commit_port.sv
// Testbench for veri_commit_port: scoreboard of accepted records, popped
// and compared as the DUT reports each commit.
module tb_veri_commit_port;
    import veri_commit_pkg::*;

    localparam logic [RF_SIZE*DATA_W-1:0] INIT_RF = {8'h04, 8'h03, 8'h02, 8'h01};

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [RF_SIZE*DATA_W-1:0] init_rf_flat = INIT_RF;
    logic                      cm_valid = 1'b0;
    logic                      cm_ready;
    logic [PC_W-1:0]           cm_pc = '0;
    logic                      cm_wen = 1'b0;
    logic [RF_IDX_W-1:0]       cm_rd = '0;
    logic [DATA_W-1:0]         cm_data = '0;
    logic                      veri_commit;
    logic [PC_W-1:0]           veri_pc_last;
    logic [RF_SIZE*DATA_W-1:0] veri_rf_flat;
    logic [CNT_W-1:0]          veri_commit_cnt;
    logic                      veri_live;

    always #5 clk = ~clk;

    veri_commit_port dut (
        .clk             (clk),
        .rst             (rst),
        .init_rf_flat    (init_rf_flat),
        .cm_valid        (cm_valid),
        .cm_ready        (cm_ready),
        .cm_pc           (cm_pc),
        .cm_wen          (cm_wen),
        .cm_rd           (cm_rd),
        .cm_data         (cm_data),
        .veri_commit     (veri_commit),
        .veri_pc_last    (veri_pc_last),
        .veri_rf_flat    (veri_rf_flat),
        .veri_commit_cnt (veri_commit_cnt),
        .veri_live       (veri_live)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    cm_rec_t           sb[$];
    logic [DATA_W-1:0] rf_m [RF_SIZE];
    logic [CNT_W-1:0]  cnt_m = '0;
    int                idle_m = 0;
    logic [PC_W-1:0]   pc_m = '0;
    logic              commit_m = 1'b0;

    function automatic logic [RF_SIZE*DATA_W-1:0] rf_flat_m();
        logic [RF_SIZE*DATA_W-1:0] f;
        f = '0;
        for (int p = 0; p < RF_SIZE; p++) begin
            f[p*DATA_W +: DATA_W] = rf_m[p];
        end
        return f;
    endfunction

    // One clock cycle: drive inputs at the negedge, update the model at the
    // posedge, compare every output at the following negedge.
    task automatic step(input bit r, input bit v, input logic [PC_W-1:0] pc, input bit wen,
                        input logic [RF_IDX_W-1:0] rd, input logic [DATA_W-1:0] data);
        cm_rec_t rec;
        cm_rec_t hd;
        bit      exp_ready;
        bit      acc;
        rst      = r;
        cm_valid = v;
        cm_pc    = pc;
        cm_wen   = wen;
        cm_rd    = rd;
        cm_data  = data;
        #1;
        exp_ready = !r && (sb.size() < Q_DEPTH);
        check_val("cm_ready", 32'(cm_ready), 32'(exp_ready));
        acc = v && exp_ready;
        rec = '{pc: pc, wen: wen, rd: rd, data: data};
        @(posedge clk);
        if (r) begin
            sb.delete();
            for (int p = 0; p < RF_SIZE; p++) rf_m[p] = INIT_RF[p*DATA_W +: DATA_W];
            cnt_m    = '0;
            idle_m   = 0;
            pc_m     = '0;
            commit_m = 1'b0;
        end else begin
            if (sb.size() > 0) begin
                hd       = sb.pop_front();
                commit_m = 1'b1;
                pc_m     = hd.pc;
                cnt_m    = cnt_m + 1'b1;
                idle_m   = 0;
                if (hd.wen) rf_m[hd.rd] = hd.data;
            end else begin
                commit_m = 1'b0;
                if (idle_m < WDOG_MAX) idle_m++;
            end
            if (acc) sb.push_back(rec);
        end
        @(negedge clk);
        check_val("veri_commit", 32'(veri_commit), 32'(commit_m));
        check_val("veri_pc_last", 32'(veri_pc_last), 32'(pc_m));
        check_val("veri_rf_flat", veri_rf_flat, rf_flat_m());
        check_val("veri_commit_cnt", 32'(veri_commit_cnt), 32'(cnt_m));
        check_val("veri_live", 32'(veri_live), 32'(idle_m < WDOG_MAX));
        if (commit_m) begin
            $display("commit pc=%0d cnt=%0d rf=%h live=%0b", pc_m, cnt_m, rf_flat_m(), veri_live);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        @(negedge clk);

        // 1: reset loads init RF
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 4'd9, 1'b1, 2'd0, 8'h77);
        check_val("t1_rf_init", veri_rf_flat, 32'h04030201);
        check_val("t1_live", 32'(veri_live), 32'd1);

        // 2: single record, visible after the second edge
        step(1'b0, 1'b1, 4'd3, 1'b1, 2'd2, 8'hAA);
        check_val("t2_no_bypass", 32'(veri_commit), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0, '0, '0);
        check_val("t2_pc_last", 32'(veri_pc_last), 32'd3);
        check_val("t2_rf2", 32'(veri_rf_flat[2*DATA_W +: DATA_W]), 32'hAA);
        check_val("t2_cnt", 32'(veri_commit_cnt), 32'd1);
        idle_steps(1);

        // 3: valid held six cycles, one commit per cycle
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, PC_W'(i + 8), 1'b1, RF_IDX_W'(i), DATA_W'(8'h30 + i));
        end
        idle_steps(2);
        check_val("t3_cnt", 32'(veri_commit_cnt), 32'd7);

        // 4: non-writing record, then back-to-back writes to r1
        step(1'b0, 1'b1, 4'd5, 1'b0, 2'd3, 8'hFF);
        step(1'b0, 1'b1, 4'd6, 1'b1, 2'd1, 8'h11);
        check_val("t4_pc_wen0", 32'(veri_pc_last), 32'd5);
        step(1'b0, 1'b1, 4'd7, 1'b1, 2'd1, 8'h22);
        idle_steps(2);
        check_val("t4_rf1", 32'(veri_rf_flat[1*DATA_W +: DATA_W]), 32'h22);

        // 5: watchdog drops after WDOG_MAX idle cycles, recovers on commit
        idle_steps(11);
        check_val("t5_live_low", 32'(veri_live), 32'd0);
        step(1'b0, 1'b1, 4'd2, 1'b1, 2'd0, 8'h5C);
        step(1'b0, 1'b0, '0, 1'b0, '0, '0);
        check_val("t5_live_back", 32'(veri_live), 32'd1);

        // 6: stream of records cut off by a mid-stream reset
        step(1'b0, 1'b1, 4'd1, 1'b1, 2'd3, 8'hD1);
        step(1'b0, 1'b1, 4'd2, 1'b1, 2'd3, 8'hD2);
        step(1'b0, 1'b1, 4'd3, 1'b1, 2'd0, 8'hD3);
        step(1'b1, 1'b1, 4'd4, 1'b1, 2'd0, 8'hD4);
        idle_steps(3);
        check_val("t6_cnt", 32'(veri_commit_cnt), 32'd0);
        check_val("t6_rf", veri_rf_flat, 32'h04030201);

        // Random traffic with occasional resets
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), PC_W'($urandom),
                 1'($urandom_range(0, 1)), RF_IDX_W'($urandom), DATA_W'($urandom));
        end
        idle_steps(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
